fifo_fill_ctrl: RTL and testbench

//  Read-side counterpart of the write-side FIFO status controller. Sits between the VDMA read

---
 rtl/fifo_fill_ctrl.sv | 154 +++++++++++++++
 tb/tb_fifo_fill_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: read-side FIFO fill controller for the VDMA line read path.
// Splits each line into BURST_LEN bursts plus one shorter tail burst. A burst is
// requested only once the FIFO has room for all of it.
// Optional macro FILL_ERR_EN adds a sticky err output for protocol violations.
module fifo_fill_ctrl #(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned BURST_LEN = 100,
    parameter int unsigned LSIZE     = 9,
    parameter int unsigned CSIZE     = 10,
    parameter int unsigned LINE_W    = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              line_start,
    input  logic [LINE_W-1:0] line_len,
    input  logic [CSIZE-1:0]  count,
    input  logic              fifo_full,
    output logic              burst_req,
    output logic [LSIZE-1:0]  req_len,
    input  logic              resp,
    input  logic              done,
    output logic              busy,
    output logic              line_done
`ifdef FILL_ERR_EN
    ,
    output logic              err
`endif
);

    // Free space is computed one bit wider than the fill level so DEPTH itself fits.
    localparam int unsigned FREE_W = CSIZE + 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REQ,
        WAIT_DONE,
        FSH
    } state_t;

    state_t            state;
    state_t            nstate;
    logic [LINE_W-1:0] remaining;
    logic [LINE_W-1:0] remaining_nxt;
    logic [LSIZE-1:0]  req_len_nxt;
    logic [LSIZE-1:0]  len_c;
    logic [FREE_W-1:0] free_c;
    logic [LINE_W-1:0] rem_after_c;
    logic              room_c;

    // Length of the next burst and free words in the FIFO.
    always_comb begin
        if (remaining < LINE_W'(BURST_LEN)) begin
            len_c = LSIZE'(remaining);
        end else begin
            len_c = LSIZE'(BURST_LEN);
        end
        if ({1'b0, count} >= FREE_W'(DEPTH)) begin
            free_c = '0;
        end else begin
            free_c = FREE_W'(DEPTH) - {1'b0, count};
        end
        room_c      = (free_c >= FREE_W'(len_c)) && !fifo_full;
        rem_after_c = remaining - LINE_W'(req_len);
    end

    // Next-state logic; resp and done together in REQ take the done path directly.
    always_comb begin
        nstate        = state;
        remaining_nxt = remaining;
        req_len_nxt   = req_len;
        case (state)
            IDLE: begin
                if (line_start) begin
                    if (line_len != '0) begin
                        nstate        = CHECK;
                        remaining_nxt = line_len;
                    end else begin
                        nstate = FSH;
                    end
                end
            end
            CHECK: begin
                if (room_c) begin
                    nstate      = REQ;
                    req_len_nxt = len_c;
                end
            end
            REQ: begin
                if (resp) begin
                    if (done) begin
                        remaining_nxt = rem_after_c;
                        nstate        = (rem_after_c == '0) ? FSH : CHECK;
                    end else begin
                        nstate = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    remaining_nxt = rem_after_c;
                    nstate        = (rem_after_c == '0) ? FSH : CHECK;
                end
            end
            FSH: begin
                nstate = IDLE;
            end
            default: begin
                nstate = IDLE;
            end
        endcase
    end

    // State, line bookkeeping and registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            req_len   <= '0;
            burst_req <= 1'b0;
            busy      <= 1'b0;
            line_done <= 1'b0;
        end else begin
            state     <= nstate;
            remaining <= remaining_nxt;
            req_len   <= req_len_nxt;
            burst_req <= (nstate == REQ);
            busy      <= (nstate != IDLE);
            line_done <= (nstate == FSH);
        end
    end

`ifdef FILL_ERR_EN
    logic err_evt_c;

    // Protocol violations seen by the controller.
    always_comb begin
        err_evt_c = (line_start && (state != IDLE))
                 || (done && ((state == IDLE) || (state == CHECK) || (state == FSH)))
                 || (resp && (state != REQ))
                 || ({1'b0, count} > FREE_W'(DEPTH));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err | err_evt_c;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed self-checking bench for fifo_fill_ctrl (default parameters).
module tb_fifo_fill_ctrl;

    logic        clock;
    logic        rst_n;
    logic        line_start;
    logic [15:0] line_len;
    logic [9:0]  count;
    logic        fifo_full;
    logic        burst_req;
    logic [8:0]  req_len;
    logic        resp;
    logic        done;
    logic        busy;
    logic        line_done;
`ifdef FILL_ERR_EN
    logic        err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    fifo_fill_ctrl dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .line_start (line_start),
        .line_len   (line_len),
        .count      (count),
        .fifo_full  (fifo_full),
        .burst_req  (burst_req),
        .req_len    (req_len),
        .resp       (resp),
        .done       (done),
        .busy       (busy),
        .line_done  (line_done)
`ifdef FILL_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [8:0] lens [3];
        lens[0] = 9'd100;
        lens[1] = 9'd100;
        lens[2] = 9'd50;

        rst_n      = 1'b0;
        line_start = 1'b0;
        line_len   = '0;
        count      = '0;
        fifo_full  = 1'b0;
        resp       = 1'b0;
        done       = 1'b0;
        tick();
        tick();
        chk("rst_burst_req", 32'(burst_req), 32'd0);
        chk("rst_req_len",   32'(req_len),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_line_done", 32'(line_done), 32'd0);
`ifdef FILL_ERR_EN
        chk("rst_err",       32'(err),       32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: 250 beats -> bursts of 100, 100, 50
        line_start = 1'b1;
        line_len   = 16'd250;
        tick();
        line_start = 1'b0;
        chk("t1_busy_check", 32'(busy),      32'd1);
        chk("t1_req_check",  32'(burst_req), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_req_%0d", i),     32'(burst_req), 32'd1);
            chk($sformatf("t1_len_%0d", i),     32'(req_len),   32'(lens[i]));
            resp = 1'b1;
            tick();
            resp = 1'b0;
            chk($sformatf("t1_req_fall_%0d", i), 32'(burst_req), 32'd0);
            chk($sformatf("t1_len_hold_%0d", i), 32'(req_len),   32'(lens[i]));
            tick();
            chk($sformatf("t1_wait_%0d", i),     32'(burst_req), 32'd0);
            done = 1'b1;
            tick();
            done = 1'b0;
            if (i < 2) begin
                chk($sformatf("t1_ld_lo_%0d", i), 32'(line_done), 32'd0);
                tick();
            end else begin
                chk("t1_ld_hi",   32'(line_done), 32'd1);
                chk("t1_busy_fsh", 32'(busy),     32'd1);
                tick();
                chk("t1_ld_end",   32'(line_done), 32'd0);
                chk("t1_busy_end", 32'(busy),      32'd0);
            end
        end

        // 2: count=450 leaves only 62 free words
        count      = 10'd450;
        line_start = 1'b1;
        line_len   = 16'd100;
        tick();
        line_start = 1'b0;
        tick();
        tick();
        chk("t2_stall_450", 32'(burst_req), 32'd0);
        count     = 10'd412;
        fifo_full = 1'b1;
        tick();
        chk("t2_stall_full", 32'(burst_req), 32'd0);
        fifo_full = 1'b0;
        tick();
        chk("t2_req_412", 32'(burst_req), 32'd1);
        chk("t2_len_412", 32'(req_len),   32'd100);
        count = 10'd0;
        resp  = 1'b1;
        tick();
        resp = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t2_ld", 32'(line_done), 32'd1);
        tick();

        // 3: zero-length line
        line_start = 1'b1;
        line_len   = 16'd0;
        tick();
        line_start = 1'b0;
        chk("t3_ld_hi",   32'(line_done), 32'd1);
        chk("t3_busy_hi", 32'(busy),      32'd1);
        chk("t3_no_req",  32'(burst_req), 32'd0);
        tick();
        chk("t3_ld_lo",   32'(line_done), 32'd0);
        chk("t3_busy_lo", 32'(busy),      32'd0);

        // 4: resp and done together on the only burst
        line_start = 1'b1;
        line_len   = 16'd100;
        tick();
        line_start = 1'b0;
        tick();
        chk("t4_req", 32'(burst_req), 32'd1);
        resp = 1'b1;
        done = 1'b1;
        tick();
        resp = 1'b0;
        done = 1'b0;
        chk("t4_req_fall", 32'(burst_req), 32'd0);
        chk("t4_ld_hi",    32'(line_done), 32'd1);
        tick();
        chk("t4_ld_lo",   32'(line_done), 32'd0);
        chk("t4_busy_lo", 32'(busy),      32'd0);

        // 5: second line_start while busy is ignored
        line_start = 1'b1;
        line_len   = 16'd150;
        tick();
        line_start = 1'b0;
        tick();
        chk("t5_len_a", 32'(req_len), 32'd100);
        line_start = 1'b1;
        line_len   = 16'd30;
        tick();
        line_start = 1'b0;
        chk("t5_req_kept", 32'(burst_req), 32'd1);
        chk("t5_len_kept", 32'(req_len),   32'd100);
`ifdef FILL_ERR_EN
        chk("t5_err_set", 32'(err), 32'd1);
`endif
        resp = 1'b1;
        tick();
        resp = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t5_ld_mid", 32'(line_done), 32'd0);
        tick();
        chk("t5_len_b", 32'(req_len),   32'd50);
        chk("t5_req_b", 32'(burst_req), 32'd1);
        resp = 1'b1;
        done = 1'b1;
        tick();
        resp = 1'b0;
        done = 1'b0;
        chk("t5_ld", 32'(line_done), 32'd1);
        tick();
`ifdef FILL_ERR_EN
        chk("t5_err_sticky", 32'(err), 32'd1);
`endif

        // done / resp while idle are ignored
        done = 1'b1;
        resp = 1'b1;
        tick();
        done = 1'b0;
        resp = 1'b0;
        chk("idle_evt_busy", 32'(busy),      32'd0);
        chk("idle_evt_req",  32'(burst_req), 32'd0);
        chk("idle_evt_ld",   32'(line_done), 32'd0);

        // 6: asynchronous reset during WAIT_DONE
        line_start = 1'b1;
        line_len   = 16'd250;
        tick();
        line_start = 1'b0;
        tick();
        resp = 1'b1;
        tick();
        resp = 1'b0;
        chk("t6_wait_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_busy",    32'(busy),      32'd0);
        chk("t6_async_req_len", 32'(req_len),   32'd0);
        chk("t6_async_req",     32'(burst_req), 32'd0);
        chk("t6_async_ld",      32'(line_done), 32'd0);
`ifdef FILL_ERR_EN
        chk("t6_async_err",     32'(err),       32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_post_idle", 32'(busy), 32'd0);
        line_start = 1'b1;
        line_len   = 16'd50;
        tick();
        line_start = 1'b0;
        tick();
        chk("t6_new_req", 32'(burst_req), 32'd1);
        chk("t6_new_len", 32'(req_len),   32'd50);
        resp = 1'b1;
        tick();
        resp = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t6_new_ld", 32'(line_done), 32'd1);
        tick();
        chk("t6_new_end", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
